// File: rtl/vga_scan.sv
// VGA raster scan generator with a game-over skull overlay and blinking eyes.
// x/y present the current pixel; rgb and syncs are registered one pixel later.
module vga_scan #(
  parameter int CLK_DIV      = 2,
  parameter int H_VIS        = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VIS        = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int BLINK_FRAMES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gameover,
  input  logic               skull,
  input  logic               eyes,
  output logic signed [10:0] x,
  output logic signed [10:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic [7:0]         rgb,
  output logic               frame_tick
);

  localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BLINK_W = $clog2(BLINK_FRAMES) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
  localparam logic [10:0] H_VIS_C  = 11'(H_VIS);
  localparam logic [10:0] V_VIS_C  = 11'(V_VIS);
  localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [10:0]        hcnt_q, hcnt_d;
  logic [10:0]        vcnt_q, vcnt_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic [7:0]         rgb_q, rgb_d;
  logic               frame_tick_q, frame_tick_d;

  logic pix_tick, h_wrap, v_wrap, visible, eye_on;

  assign pix_tick = (div_q == DIV_LAST);
  assign h_wrap   = (hcnt_q == H_LAST);
  assign v_wrap   = (vcnt_q == V_LAST);
  assign visible  = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
  // Counter top bit splits the 2*BLINK_FRAMES period into on/off halves.
  assign eye_on   = ~blink_q[BLINK_W-1];

  always_comb begin
    div_d        = pix_tick ? '0 : div_q + DIV_W'(1);
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    rgb_d        = rgb_q;
    frame_tick_d = pix_tick && h_wrap && v_wrap;
    if (pix_tick) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 11'd1;
      if (h_wrap) begin
        vcnt_d = v_wrap ? '0 : vcnt_q + 11'd1;
      end
      // Decoded from the pixel being presented, so they lag x,y by one pixel.
      hsync_d = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
      vsync_d = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
      if (!visible) begin
        rgb_d = 8'h00;
      end else if (gameover && eyes && eye_on) begin
        rgb_d = 8'hE0;
      end else if (gameover && skull) begin
        rgb_d = 8'hFF;
      end else begin
        rgb_d = 8'h00;
      end
    end
    blink_d = blink_q;
    if (!gameover) begin
      blink_d = '0;
    end else if (frame_tick_d) begin
      blink_d = blink_q + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      blink_q      <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      rgb_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      blink_q      <= blink_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      rgb_q        <= rgb_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign x          = hcnt_q;
  assign y          = vcnt_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign rgb        = rgb_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan: two instances (CLK_DIV 2 and 1) on a shrunken raster,
// checked each clock against an arithmetic position/colour model.
module tb_vga_scan;

  localparam int H_VIS = 6, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int V_VIS = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int BF    = 4;
  localparam int HT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV0  = 2;
  localparam int DIV1  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1, gameover = 1'b0, skull = 1'b0, eyes = 1'b0;
  logic signed [10:0] x0, y0, x1, y1;
  logic hs0, vs0, ft0, hs1, vs1, ft1;
  logic [7:0] rgb0, rgb1;

  always #5 clk = ~clk;

  vga_scan #(.CLK_DIV(DIV0), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
             .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .BLINK_FRAMES(BF))
  dut (.clk(clk), .rst(rst), .gameover(gameover), .skull(skull), .eyes(eyes),
       .x(x0), .y(y0), .hsync(hs0), .vsync(vs0), .rgb(rgb0), .frame_tick(ft0));

  vga_scan #(.CLK_DIV(DIV1), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
             .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .BLINK_FRAMES(BF))
  dut1 (.clk(clk), .rst(rst), .gameover(gameover), .skull(skull), .eyes(eyes),
        .x(x1), .y(y1), .hsync(hs1), .vsync(vs1), .rgb(rgb1), .frame_tick(ft1));

  int checks = 0;
  int errors = 0;

  // Reference state: clocks since reset release and frames shown with gameover high.
  int         k[2];
  int         blink[2];
  logic [7:0] e_rgb[2];
  logic       e_hs[2], e_vs[2], e_ft[2];

  typedef struct {
    logic       go;
    logic       sk;
    logic       ey;
    logic [7:0] rgb;
  } vec_t;
  vec_t tbl[6];

  function automatic int dv(int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  function automatic int px(int i);
    return (k[i] / dv(i)) % HT;
  endfunction

  function automatic int py(int i);
    return ((k[i] / dv(i)) / HT) % VT;
  endfunction

  function automatic logic [32:0] exp_vec(int i);
    return {11'(px(i)), 11'(py(i)), e_hs[i], e_vs[i], e_rgb[i], e_ft[i]};
  endfunction

  function automatic logic [32:0] act_vec(int i);
    return (i == 0) ? {x0, y0, hs0, vs0, rgb0, ft0} : {x1, y1, hs1, vs1, rgb1, ft1};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input int i, input logic r, input logic go, input logic sk, input logic ey);
    int d, p, h, v;
    bit wrap, eo;
    d = dv(i);
    if (r) begin
      k[i] = 0; blink[i] = 0; e_rgb[i] = 8'h00;
      e_hs[i] = 1'b1; e_vs[i] = 1'b1; e_ft[i] = 1'b0;
      return;
    end
    k[i]++;
    wrap = 1'b0;
    if (k[i] % d == 0) begin
      p  = k[i] / d - 1;
      h  = p % HT;
      v  = (p / HT) % VT;
      eo = (blink[i] < BF);
      if (!(h < H_VIS && v < V_VIS)) e_rgb[i] = 8'h00;
      else if (go && ey && eo)       e_rgb[i] = 8'hE0;
      else if (go && sk)             e_rgb[i] = 8'hFF;
      else                           e_rgb[i] = 8'h00;
      e_hs[i] = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
      e_vs[i] = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
      wrap = ((k[i] / d) % (HT * VT)) == 0;
    end
    e_ft[i] = wrap;
    if (!go) blink[i] = 0;
    else if (wrap) blink[i] = (blink[i] + 1) % (2 * BF);
  endtask

  task automatic step(input logic r, input logic go, input logic sk, input logic ey);
    @(negedge clk);
    rst = r; gameover = go; skull = sk; eyes = ey;
    @(posedge clk);
    model(0, r, go, sk, ey);
    model(1, r, go, sk, ey);
    #1;
    chk("scan_div2", act_vec(0), exp_vec(0));
    chk("scan_div1", act_vec(1), exp_vec(1));
  endtask

  // Steps until instance 0 has just begun presenting pixel (tx,ty).
  task automatic run_to(input int tx, input int ty, input logic go, input logic sk, input logic ey);
    for (int n = 0; n < HT * VT * DIV0 + 4; n++) begin
      step(1'b0, go, sk, ey);
      if (px(0) == tx && py(0) == ty && k[0] % DIV0 == 0) return;
    end
    checks++; errors++;
    $display("FAIL run_to_timeout: position %0d,%0d not reached", tx, ty);
  endtask

  task automatic do_reset(input logic go);
    repeat (3) step(1'b1, go, 1'b0, 1'b0);
  endtask

  initial begin
    int   t, cnt, fx, fy, n;
    int   hf[2], ftt[2], nft[2];
    bit   first_hs[2];
    logic prev_hs[2], prev_vs[2], go;
    logic [32:0] av;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'hE0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'hE0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 8'h00};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00};

    do_reset(1'b0);
    chk("reset_state0", {x0, y0, hs0, vs0, rgb0, ft0}, {22'd0, 1'b1, 1'b1, 8'h00, 1'b0});
    chk("reset_state1", {x1, y1, hs1, vs1, rgb1, ft1}, {22'd0, 1'b1, 1'b1, 8'h00, 1'b0});

    // One table entry per visible pixel of line 0 on the CLK_DIV=2 instance.
    foreach (tbl[i]) begin
      repeat (DIV0) step(1'b0, tbl[i].go, tbl[i].sk, tbl[i].ey);
      chk("colour_table", rgb0, tbl[i].rgb);
    end

    // Sync/frame timing on both instances.
    do_reset(1'b0);
    t = 0;
    for (int i = 0; i < 2; i++) begin
      hf[i] = -1; ftt[i] = -1; nft[i] = 0; first_hs[i] = 1'b0;
      prev_hs[i] = 1'b1; prev_vs[i] = 1'b1;
    end
    for (int c = 0; c < 3 * HT * VT * DIV0; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      t++;
      for (int i = 0; i < 2; i++) begin
        av = act_vec(i);
        if (prev_hs[i] && !av[10]) begin
          if (hf[i] >= 0) chk("hsync_period", t - hf[i], HT * dv(i));
          if (first_hs[i]) chk("hsync_start", t - ftt[i], (H_VIS + H_FP + 1) * dv(i));
          first_hs[i] = 1'b0;
          hf[i] = t;
        end
        if (!prev_hs[i] && av[10] && hf[i] >= 0) chk("hsync_low", t - hf[i], H_SYNC * dv(i));
        if (prev_vs[i] && !av[9] && ftt[i] >= 0)
          chk("vsync_start", t - ftt[i], ((V_VIS + V_FP) * HT + 1) * dv(i));
        if (!prev_vs[i] && av[9] && ftt[i] >= 0)
          chk("vsync_low", t - ftt[i], ((V_VIS + V_FP + V_SYNC) * HT + 1) * dv(i));
        if (av[0]) begin
          if (ftt[i] >= 0) chk("frame_period", t - ftt[i], HT * VT * dv(i));
          else chk("first_frame_tick", t, HT * VT * dv(i));
          ftt[i] = t; nft[i]++; first_hs[i] = 1'b1;
        end
        prev_hs[i] = av[10];
        prev_vs[i] = av[9];
      end
    end
    chk("frame_ticks_div2", nft[0], 3);
    chk("frame_ticks_div1", nft[1], 6);

    // Single skull pixel at (3,2) appears one pixel late, for one pixel only.
    do_reset(1'b1);
    cnt = 0; fx = -1; fy = -1;
    for (int c = 0; c < HT * VT * DIV0 + 2 * HT * DIV0; c++) begin
      step(1'b0, 1'b1, (px(0) == 3 && py(0) == 2), 1'b0);
      if (rgb0 === 8'hFF) begin
        if (cnt == 0) begin fx = px(0); fy = py(0); end
        cnt++;
      end
    end
    chk("align_clks", cnt, DIV0);
    chk("align_x", fx, 4);
    chk("align_y", fy, 2);

    // Blink phases and priority with eyes and skull both high.
    do_reset(1'b1);
    for (int f = 0; f <= 2 * BF; f++) begin
      run_to(2, 1, 1'b1, 1'b1, 1'b1);
      chk("blink_frame", rgb0, (f % (2 * BF) < BF) ? 8'hE0 : 8'hFF);
    end
    run_to(2, 1, 1'b0, 1'b1, 1'b1);
    chk("gameover_low", rgb0, 8'h00);
    for (int g = 1; g <= BF; g++) begin
      run_to(2, 1, 1'b1, 1'b1, 1'b1);
      chk("blink_restart", rgb0, (g < BF) ? 8'hE0 : 8'hFF);
    end

    // Reset mid-frame aborts the scan and restarts frame timing.
    run_to(4, 2, 1'b1, 1'b1, 1'b0);
    chk("pre_reset_rgb", rgb0, 8'hFF);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("midrst_state", {x0, y0, hs0, vs0, rgb0}, {22'd0, 1'b1, 1'b1, 8'h00});
    n = 0;
    for (int c = 0; c < 2 * HT * VT * DIV0; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
      if (ft0 === 1'b1) break;
    end
    chk("restart_frame_tick", n, HT * VT * DIV0);

    // Random traffic with occasional resets and slow gameover changes.
    go = 1'b1;
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 2999) == 0) go = ~go;
      step(($urandom_range(0, 2999) == 0), go, 1'($urandom % 2), 1'($urandom % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan.md
VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per pixel; legal values are 1 to 8.
REQ-002 Parameter H_VIS, default 640: visible pixels per line.
REQ-003 Parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync width and back porch, in pixels.
REQ-004 Parameter V_VIS, default 480: visible lines per frame.
REQ-005 Parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical front porch, sync width and back porch, in lines.
REQ-006 Parameter BLINK_FRAMES, default 32: eye on/off half-period, in frames; must be a power of two.
REQ-007 clk  input  1  system clock; the only clock in the block.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 gameover  input  1  game-over screen enable.
REQ-010 skull  input  1  skull pixel flag, returned combinationally by the drawing logic for the current x,y.
REQ-011 eyes  input  1  eye pixel flag, returned combinationally by the drawing logic for the current x,y.
REQ-012 x  output  11 signed  current horizontal scan position.
REQ-013 y  output  11 signed  current vertical scan position.
REQ-014 hsync  output  1  horizontal sync, active-low.
REQ-015 vsync  output  1  vertical sync, active-low.
REQ-016 rgb  output  8  colour {R[2:0], G[2:0], B[1:0]}.
REQ-017 frame_tick  output  1  one-clk pulse at the start of each frame.

Function
REQ-018 A divider counts 0 to CLK_DIV-1; pix_tick is asserted for the clk cycle in which the divider equals CLK_DIV-1.
REQ-019 hcnt advances only on pix_tick and runs 0 to H_TOT-1, where H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800 at defaults); it then wraps to 0.
REQ-020 vcnt advances only on a pix_tick at which hcnt wraps, and runs 0 to V_TOT-1 (525 at defaults); it then wraps to 0.
REQ-021 x equals hcnt and y equals vcnt, zero-extended to 11 bits; both are registered outputs.
REQ-022 The scan is visible when hcnt < H_VIS and vcnt < V_VIS.
REQ-023 Raw hsync is low when H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC; raw vsync is low on the equivalent vcnt range.
REQ-024 Pipeline: skull and eyes are sampled on the pix_tick edge following x,y; rgb, hsync and vsync are registered on that same edge, so all three lag x,y by exactly one pixel and stay aligned to each other.
REQ-025 rgb selection, in priority order:
- not visible -> 8'h00;
- gameover and eyes and eye_on -> 8'hE0;
- gameover and skull -> 8'hFF;
- otherwise -> 8'h00.
REQ-026 The blink counter increments once per frame, on the frame wrap.
REQ-027 The blink counter is cleared whenever gameover is low.
REQ-028 eye_on is 1 for blink counts 0 to BLINK_FRAMES-1 and 0 for counts BLINK_FRAMES to 2*BLINK_FRAMES-1; the counter then wraps to 0.
REQ-029 frame_tick is high for exactly one clk: the pix_tick cycle in which both hcnt and vcnt wrap to 0.
REQ-030 A gameover change takes effect at the next registered pixel; there is no frame-boundary synchronisation.
REQ-031 When eyes and skull overlap with eye_on low, the pixel shows the skull colour (8'hFF).
REQ-032 Outputs change only on clk edges where pix_tick is high, except frame_tick, which is single-clk wide.

Reset
REQ-033 While rst is high, every clk edge sets:
- divider = 0, hcnt = 0, vcnt = 0, blink = 0;
- x = 0, y = 0;
- hsync = 1, vsync = 1;
- rgb = 8'h00, frame_tick = 0.
REQ-034 rst asserted mid-line or mid-frame aborts the scan immediately; the scan restarts at hcnt = 0, vcnt = 0 on the first pix_tick after rst is released.
REQ-035 The first pix_tick after reset occurs CLK_DIV clk cycles after rst deasserts.

Verification
REQ-036 Timing: defaults, rst for 3 clks, run 2 frames -> hsync period 1600 clks, low for 192 clks starting 1312 clks (656 pixels) after hcnt=0; vsync low for 2 lines beginning at line 490; frame_tick every 840000 clks.
REQ-037 Colour alignment: gameover=1, drive skull=1 only when x==300 && y==290 -> rgb=8'hFF for exactly one pixel, appearing the pixel after x==300 is presented; rgb=8'h00 elsewhere.
REQ-038 Blanking: gameover=1, skull and eyes held high -> rgb=8'h00 whenever the lagged hcnt >= 640 or vcnt >= 480.
REQ-039 Blink and priority: gameover=1, eyes=skull=1 continuously -> frames 0-31 show 8'hE0 and frames 32-63 show 8'hFF; dropping gameover for 1 frame and raising it again restarts the count at frame 0.
REQ-040 Reset mid-frame: assert rst at hcnt=400, vcnt=200 for 1 clk -> next cycle x=0, y=0, hsync=1, vsync=1, rgb=0; the following frame_tick arrives 840000 clks after restart.
REQ-041 CLK_DIV=1: repeat the timing scenario -> hsync period 800 clks, all other counts halved.
